// File: rtl/dshift_seq.sv
// Command sequencer for a bidirectional DEPTH-word shift chain: pulls len words
// from an upstream stream, then presents the assembled vector downstream.
module dshift_seq #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dir,
    input  logic [CW-1:0]         len,
    input  logic                  abort,
    output logic                  busy,
    output logic                  err,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW-1:0]         in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW*DEPTH-1:0]   dout,
    output logic                  done
);

    localparam int unsigned VW = DW * DEPTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_dir;
    logic [CW-1:0] r_len;
    logic [CW-1:0] r_count;

    logic [CW-1:0] w_count_nxt;
    logic          w_len_ok;
    logic          w_beat;

    assign w_count_nxt = r_count + CW'(1);
    assign w_len_ok    = (len != '0) && (len <= DEPTH_C);
    assign w_beat      = in_valid && in_ready;

    // Single-process FSM; every output is a flop updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_dir     <= 1'b0;
            r_len     <= '0;
            r_count   <= '0;
            dout      <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            err  <= 1'b0;
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_len_ok) begin
                            r_dir    <= dir;
                            r_len    <= len;
                            r_count  <= '0;
                            dout     <= '0;
                            r_state  <= FILL;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (abort) begin
                        // A beat coincident with abort is consumed but not stored.
                        r_state  <= IDLE;
                        busy     <= 1'b0;
                        in_ready <= 1'b0;
                    end else if (w_beat) begin
                        if (r_dir) begin
                            dout <= {in_data, dout[VW-1:DW]};
                        end else begin
                            dout <= {dout[VW-DW-1:0], in_data};
                        end
                        r_count <= w_count_nxt;
                        if (w_count_nxt == r_len) begin
                            r_state   <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (abort) begin
                        r_state   <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                    end else if (out_ready) begin
                        r_state   <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    busy      <= 1'b0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dshift_seq.md
Name: dshift_seq

Overview:
- Sequencer for the bidirectional word shift chain used to assemble multi-word operand vectors for the EKF datapath.
- Accepts a command (direction, word count), pulls that many words from an upstream valid/ready stream, and shifts each word into an internal DEPTH-word chain.
- Presents the assembled parallel vector downstream with a valid/ready handshake, then returns to idle with a done pulse.

Parameters:
- DW, 16, word width in bits.
- DEPTH, 4, number of words in the shift chain.
- CW, 3, width of the len and count fields; must hold the value DEPTH.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, command strobe; sampled only in IDLE.
- dir, input, 1, shift direction for the command; 0 = toward high words, 1 = toward low words.
- len, input, CW, number of words to load; legal range 1..DEPTH.
- abort, input, 1, cancels the current command.
- busy, output, 1, high in FILL and HOLD.
- err, output, 1, one-cycle pulse when a command is rejected.
- in_valid, input, 1, upstream word valid.
- in_ready, output, 1, ready for an upstream word; high only in FILL.
- in_data, input, DW, upstream word.
- out_valid, output, 1, assembled vector valid; high only in HOLD.
- out_ready, input, 1, downstream accepts the vector.
- dout, output, DW*DEPTH, shift chain contents; word k occupies bits [k*DW +: DW].
- done, output, 1, one-cycle pulse after the vector is accepted.

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - state to IDLE;
  - dout and the internal count to 0;
  - busy, err, in_ready, out_valid and done to 0.
  - Reset has priority over every other input, in any state, including mid-FILL and mid-HOLD.
- States and transitions:
  - IDLE:
    - start=1 with 1<=len<=DEPTH: latch dir and len, clear dout to 0, clear count, go to FILL.
    - start=1 with len=0 or len>DEPTH: err=1 for the next cycle, stay in IDLE, dout unchanged.
  - FILL:
    - in_ready=1. A beat is accepted in a cycle where in_valid and in_ready are both 1.
    - dir=0: dout <= {dout[(DEPTH-1)*DW-1:0], in_data}. The new word enters word 0; word DEPTH-1 is discarded.
    - dir=1: dout <= {in_data, dout[DEPTH*DW-1:DW]}. The new word enters word DEPTH-1; word 0 is discarded.
    - Each accepted beat increments count.
    - When the beat that brings count to len is accepted, go to HOLD.
    - Cycles with in_valid=0 leave dout and count unchanged.
  - HOLD:
    - out_valid=1 and dout is held stable.
    - out_ready=1: go to IDLE; done=1 for exactly one cycle, in the cycle after the handshake.
  - abort=1 in FILL or HOLD: go to IDLE next cycle.
    - No done pulse; dout retains its partial contents.
    - The handshake with abort coincident is still a beat but is discarded.
    - abort in IDLE has no effect.
- Timing and latency:
  - start sampled at cycle N: busy and in_ready are 1 from cycle N+1.
  - Last beat accepted at cycle M: out_valid=1 from cycle M+1; in_ready=0 from cycle M+1.
  - Minimum command duration is len+2 cycles, with in_valid and out_ready held high.
- start while busy is ignored; no err is raised.
- start coincident with the done cycle is accepted, because the state is already IDLE.
- Registered outputs: busy, in_ready, out_valid, err and done all come directly from state or flops; none is combinational on inputs.
- Partial load: with len<DEPTH, the unfilled words remain 0 from the start-time clear.
- in_data is ignored outside FILL handshake cycles.

Test Plan:
- DW=16, DEPTH=4, dir=0, len=4; feed 0x1111, 0x2222, 0x3333, 0x4444 back-to-back -> out_valid at the cycle after the 4th beat; dout = 0x1111_2222_3333_4444 (word0 = 0x4444); done one cycle after out_ready.
- dir=1, len=4, same data -> dout = 0x4444_3333_2222_1111 (word0 = 0x1111).
- dir=0, len=2; feed 0xAAAA, 0xBBBB with in_valid gaps of 2 cycles -> dout = 0x0000_0000_AAAA_BBBB; count and dout unchanged during gaps.
- start with len=0, then with len=5 -> err pulses one cycle each; busy, in_ready and dout unchanged.
- Full load; hold out_ready low for 3 cycles -> out_valid stays 1 and dout stable; done only after out_ready=1; new start issued on the done cycle is accepted.
- abort after 2 beats of a len=4 command -> IDLE next cycle, no done. rst asserted mid-HOLD -> all outputs 0 next cycle. A subsequent command then completes normally.
